axi_slave_write_responder: RTL and testbench



---
 rtl/axi_slave_write_responder_if.sv | 38 +++
 rtl/axi_slave_write_responder.sv | 150 +++++++++++++++
 tb/tb_axi_slave_write_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_write_responder_if.sv
// rtl/axi_slave_write_responder_if.sv - AXI4 write-side AW/W/B channel bundle
interface axi_slave_write_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_slave_write_responder.sv
// rtl/axi_slave_write_responder.sv - single-burst AXI4 write slave with word memory and debug port
// Define AXI_SLV_WR_STALL_EN to drop wready for one cycle after every non-final accepted beat.
module axi_slave_write_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         sig_clock,
  input  logic                         sig_reset,
  axi_slave_write_responder_if.slave   bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata,
  output logic [7:0]                   err_cnt
);
  localparam int OFF_W   = $clog2(STRB_WIDTH);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int BYTE_AW = OFF_W + IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q, id_q;
  logic [1:0]            bresp_q;
  logic [7:0]            err_cnt_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, beat_cnt_q;
  logic [2:0]            size_q;
  logic                  incr_q;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  aw_hs, w_hs, b_hs;
  logic                  aw_err, addr_in_range, last_beat, done_beat, mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [ADDR_WIDTH-1:0] addr_step;

  assign aw_hs = bus.awvalid & awready_q;
  assign w_hs  = bus.wvalid & wready_q;
  assign b_hs  = bvalid_q & bus.bready;

  // WRAP and reserved bursts, oversize beats and out-of-range starts poison the whole burst
  assign aw_err = bus.awburst[1]
                | (bus.awsize > 3'(OFF_W))
                | ((bus.awaddr >> BYTE_AW) != '0);

  assign addr_in_range = (addr_q >> BYTE_AW) == '0;
  assign mem_idx       = addr_q[OFF_W +: IDX_W];
  assign addr_step     = ADDR_WIDTH'(1) << size_q;
  assign addr_d        = incr_q ? addr_q + addr_step : addr_q;
  assign last_beat     = beat_cnt_q == len_q;
  assign done_beat     = last_beat | bus.wlast;
  assign err_d         = err_q | ~addr_in_range | (last_beat ^ bus.wlast);
  assign mem_we        = w_hs & ~err_q & addr_in_range & ~sig_reset;

  always_ff @(posedge sig_clock) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (bus.wstrb[i]) begin
          mem[mem_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      err_cnt_q   <= 8'd0;
      dbg_rdata_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      incr_q      <= 1'b0;
      beat_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      dbg_rdata_q <= mem[dbg_addr];
      case (state_q)
        S_IDLE: begin
          if (aw_hs) begin
            id_q       <= bus.awid;
            addr_q     <= bus.awaddr;
            len_q      <= bus.awlen;
            size_q     <= bus.awsize;
            incr_q     <= bus.awburst == 2'b01;
            beat_cnt_q <= 8'd0;
            err_q      <= aw_err;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= S_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            err_q      <= err_d;
            if (done_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= err_d ? 2'b10 : 2'b00;
              state_q  <= S_RESP;
            end else begin
`ifdef AXI_SLV_WR_STALL_EN
              wready_q <= 1'b0;
`else
              wready_q <= 1'b1;
`endif
            end
          end else begin
            wready_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
            if (bresp_q == 2'b10 && err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_axi_slave_write_responder.sv
// tb/tb_axi_slave_write_responder.sv - directed self-checking bench for axi_slave_write_responder
module tb_axi_slave_write_responder;
  logic        sig_clock;
  logic        sig_reset;
  logic [7:0]  dbg_addr;
  logic [63:0] dbg_rdata;
  logic [7:0]  err_cnt;
  int          checks;
  int          errors;

`ifdef AXI_SLV_WR_STALL_EN
  localparam int W_CYC4 = 7;
`else
  localparam int W_CYC4 = 4;
`endif

  axi_slave_write_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(32)) bus ();

  axi_slave_write_responder dut (
    .sig_clock (sig_clock),
    .sig_reset (sig_reset),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .err_cnt   (err_cnt)
  );

  initial sig_clock = 1'b0;
  always #5 sig_clock = ~sig_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic aw_xfer(input logic [31:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.awready) done = 1;
      @(posedge sig_clock); #1;
    end
    bus.awvalid = 1'b0;
    check("aw_handshake", done, 1);
    check("wready_after_aw", bus.wready, 1);
    check("awready_after_aw", bus.awready, 0);
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        output int cycles);
    bit done = 0;
    cycles = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.wready) done = 1;
      @(posedge sig_clock); #1;
      cycles++;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("w_handshake", done, 1);
  endtask

  task automatic b_xfer(input logic [31:0] id, input logic [1:0] resp, input int hold);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.bvalid) done = 1;
      else begin @(posedge sig_clock); #1; end
    end
    check("bvalid_seen", done, 1);
    check("bid", bus.bid, id);
    check("bresp", bus.bresp, resp);
    for (int i = 0; i < hold; i++) begin
      @(posedge sig_clock); #1;
      check("hold_bvalid", bus.bvalid, 1);
      check("hold_bid", bus.bid, id);
      check("hold_bresp", bus.bresp, resp);
      check("hold_awready", bus.awready, 0);
    end
    bus.bready = 1'b1;
    @(posedge sig_clock); #1;
    bus.bready = 1'b0;
    check("bvalid_after_b", bus.bvalid, 0);
    check("awready_after_b", bus.awready, 1);
  endtask

  task automatic dbg_read(input logic [7:0] idx, input logic [63:0] exp);
    dbg_addr = idx;
    @(posedge sig_clock); #1;
    check($sformatf("mem[%0d]", idx), dbg_rdata, exp);
  endtask

  initial begin
    int cyc, tot;
    checks = 0; errors = 0;
    sig_reset = 1'b1; dbg_addr = 8'd0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    repeat (3) @(posedge sig_clock);
    #1;
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    sig_reset = 1'b0;
    @(posedge sig_clock); #1;
    check("awready_after_rst", bus.awready, 1);

    // W offered before any AW must not be accepted
    bus.wvalid = 1'b1; bus.wdata = 64'hBAD; bus.wstrb = 8'hFF;
    repeat (2) begin
      @(posedge sig_clock); #1;
      check("wready_idle", bus.wready, 0);
    end
    bus.wvalid = 1'b0;

    // INCR 0x10, 4 beats of 8 bytes -> mem[2..5]
    aw_xfer(32'hA5A5_0001, 32'h10, 8'd3, 3'd3, 2'b01);
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      w_beat(64'(b + 1), 8'hFF, b == 3, cyc);
      tot += cyc;
    end
    check("incr_bvalid_latency", bus.bvalid, 1);
    check("incr_wready_drop", bus.wready, 0);
    check("incr_w_cycles", tot, W_CYC4);
    b_xfer(32'hA5A5_0001, 2'b00, 0);
    for (int i = 0; i < 4; i++) dbg_read(8'(2 + i), 64'(i + 1));

    // FIXED 0x08, 3 beats -> last one wins; bready withheld 5 cycles
    aw_xfer(32'h0000_0B0B, 32'h08, 8'd2, 3'd3, 2'b00);
    w_beat(64'hA, 8'hFF, 1'b0, cyc);
    w_beat(64'hB, 8'hFF, 1'b0, cyc);
    w_beat(64'hC, 8'hFF, 1'b1, cyc);
    b_xfer(32'h0000_0B0B, 2'b00, 5);
    dbg_read(8'd1, 64'hC);

    // strobe: clear mem[0], then write low four lanes only
    aw_xfer(32'h3, 32'h0, 8'd0, 3'd3, 2'b01);
    w_beat(64'h0, 8'hFF, 1'b1, cyc);
    b_xfer(32'h3, 2'b00, 0);
    aw_xfer(32'h3, 32'h0, 8'd0, 3'd3, 2'b01);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1, cyc);
    b_xfer(32'h3, 2'b00, 0);
    dbg_read(8'd0, 64'h0000_0000_FFFF_FFFF);

    // reserved burst type: beats accepted, memory untouched
    aw_xfer(32'h4, 32'h10, 8'd3, 3'd3, 2'b11);
    for (int b = 0; b < 4; b++) w_beat(64'hDEAD_0000 + 64'(b), 8'hFF, b == 3, cyc);
    b_xfer(32'h4, 2'b10, 0);
    check("err_cnt_1", err_cnt, 1);
    dbg_read(8'd2, 64'h1);
    dbg_read(8'd5, 64'h4);

    // early wlast on beat 2 of 4
    aw_xfer(32'h5, 32'h40, 8'd3, 3'd3, 2'b01);
    w_beat(64'h11, 8'hFF, 1'b0, cyc);
    w_beat(64'h22, 8'hFF, 1'b1, cyc);
    check("early_bvalid", bus.bvalid, 1);
    check("early_wready", bus.wready, 0);
    b_xfer(32'h5, 2'b10, 0);
    check("err_cnt_2", err_cnt, 2);
    dbg_read(8'd8, 64'h11);

    // start address out of range
    aw_xfer(32'h6, 32'h800, 8'd0, 3'd3, 2'b01);
    w_beat(64'h99, 8'hFF, 1'b1, cyc);
    b_xfer(32'h6, 2'b10, 0);
    check("err_cnt_3", err_cnt, 3);

    // INCR running off the top of memory: first beat lands, second errors
    aw_xfer(32'h7, 32'h7F8, 8'd1, 3'd3, 2'b01);
    w_beat(64'h55, 8'hFF, 1'b0, cyc);
    w_beat(64'h66, 8'hFF, 1'b1, cyc);
    b_xfer(32'h7, 2'b10, 0);
    check("err_cnt_4", err_cnt, 4);
    dbg_read(8'd255, 64'h55);

    // beat wider than the bus
    aw_xfer(32'h8, 32'h10, 8'd0, 3'd4, 2'b01);
    w_beat(64'hBAD, 8'hFF, 1'b1, cyc);
    b_xfer(32'h8, 2'b10, 0);
    check("err_cnt_5", err_cnt, 5);
    dbg_read(8'd2, 64'h1);

    // reset after beat 1 of 4 abandons the burst
    aw_xfer(32'h9, 32'h60, 8'd3, 3'd3, 2'b01);
    w_beat(64'h77, 8'hFF, 1'b0, cyc);
    sig_reset = 1'b1;
    @(posedge sig_clock); #1;
    check("midrst_bvalid", bus.bvalid, 0);
    check("midrst_wready", bus.wready, 0);
    check("midrst_awready", bus.awready, 0);
    check("midrst_err_cnt", err_cnt, 0);
    @(posedge sig_clock); #1;
    sig_reset = 1'b0;
    @(posedge sig_clock); #1;
    check("awready_after_midrst", bus.awready, 1);
    check("no_b_after_midrst", bus.bvalid, 0);
    dbg_read(8'd12, 64'h77);

    aw_xfer(32'hA, 32'h60, 8'd3, 3'd3, 2'b01);
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      w_beat(64'h81 + 64'(b), 8'hFF, b == 3, cyc);
      tot += cyc;
    end
    check("post_rst_w_cycles", tot, W_CYC4);
    b_xfer(32'hA, 2'b00, 0);
    dbg_read(8'd12, 64'h81);
    dbg_read(8'd15, 64'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
